// File: rtl/adc_spi_capture.sv
// Periodic SPI capture front-end for a 12-bit converter with CONVST start and 6-bit config word.
// Macros: ADC_OVERRUN_FLAG_EN enables the sticky overrun flag; ADC_SKIP_PERIOD_CHECK bypasses the period check.
module adc_spi_capture #(
  parameter int CLK_HZ    = 50000000,
  parameter int SAMPLE_HZ = 96000,
  parameter int CONV_CYC  = 80,
  parameter int SCK_DIV   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  channel,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] adc_value,
  output logic        adc_valid,
  output logic        busy,
  input  logic        overrun_clr,
  output logic        overrun
);

  localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int TW = $clog2(PERIOD + 1);
  localparam int CW = $clog2(CONV_CYC + 1);
  localparam int DW = $clog2(SCK_DIV + 1);

`ifndef ADC_SKIP_PERIOD_CHECK
  // A frame (CONV + 24 SCK half-periods + DONE) must fit between two ticks.
  if (PERIOD < CONV_CYC + 24 * SCK_DIV + 2) begin : gPeriodCheck
    $error("adc_spi_capture: PERIOD too short for CONV_CYC and SCK_DIV");
  end
`endif

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tickCnt_q, tickCnt_d;
  logic [CW-1:0]   convCnt_q, convCnt_d;
  logic [DW-1:0]   divCnt_q, divCnt_d;
  logic [3:0]      bitCnt_q, bitCnt_d;
  logic [11:0]     cfg_q, cfg_d;
  logic [11:0]     shift_q, shift_d;
  logic [11:0]     value_q, value_d;
  logic            convst_q, convst_d;
  logic            sck_q, sck_d;
  logic            sdi_q, sdi_d;
  logic            valid_q, valid_d;
  logic            tick;

  always_comb begin
    tick      = (tickCnt_q == TW'(PERIOD - 1));
    tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
  end

  always_comb begin
    state_d   = state_q;
    convCnt_d = convCnt_q;
    divCnt_d  = divCnt_q;
    bitCnt_d  = bitCnt_q;
    cfg_d     = cfg_q;
    shift_d   = shift_q;
    sck_d     = sck_q;
    sdi_d     = sdi_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        sdi_d = 1'b0;
        if (tick && enable) begin
          state_d   = CONV;
          convCnt_d = '0;
          cfg_d     = {1'b1, channel[0], channel[2], channel[1], 1'b1, 7'b0};
        end
      end
      CONV: begin
        if (convCnt_q == CW'(CONV_CYC - 1)) begin
          state_d  = SHIFT;
          divCnt_d = '0;
          bitCnt_d = 4'd0;
          sck_d    = 1'b0;
          sdi_d    = cfg_q[11];
        end else begin
          convCnt_d = convCnt_q + CW'(1);
        end
      end
      SHIFT: begin
        // SDO is captured on the rising SCK edge; SDI advances on the falling one.
        if (divCnt_q == DW'(SCK_DIV - 1)) begin
          divCnt_d = '0;
          if (!sck_q) begin
            sck_d   = 1'b1;
            shift_d = {shift_q[10:0], adc_sdo};
          end else begin
            sck_d = 1'b0;
            if (bitCnt_q == 4'd11) begin
              state_d = DONE;
              sdi_d   = 1'b0;
              value_d = shift_q;
              valid_d = 1'b1;
            end else begin
              bitCnt_d = bitCnt_q + 4'd1;
              cfg_d    = {cfg_q[10:0], 1'b0};
              sdi_d    = cfg_q[10];
            end
          end
        end else begin
          divCnt_d = divCnt_q + DW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    convst_d = (state_d == CONV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tickCnt_q <= '0;
      convCnt_q <= '0;
      divCnt_q  <= '0;
      bitCnt_q  <= 4'd0;
      cfg_q     <= 12'd0;
      shift_q   <= 12'd0;
      value_q   <= 12'd0;
      convst_q  <= 1'b0;
      sck_q     <= 1'b0;
      sdi_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      convCnt_q <= convCnt_d;
      divCnt_q  <= divCnt_d;
      bitCnt_q  <= bitCnt_d;
      cfg_q     <= cfg_d;
      shift_q   <= shift_d;
      value_q   <= value_d;
      convst_q  <= convst_d;
      sck_q     <= sck_d;
      sdi_q     <= sdi_d;
      valid_q   <= valid_d;
    end
  end

  assign adc_convst = convst_q;
  assign adc_sck    = sck_q;
  assign adc_sdi    = sdi_q;
  assign adc_value  = value_q;
  assign adc_valid  = valid_q;
  assign busy       = (state_q != IDLE);

`ifdef ADC_OVERRUN_FLAG_EN
  logic overrun_q, overrun_d;

  // Set wins over clear so a drop in the clearing cycle is never lost.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (tick && enable && (state_q != IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign overrun = overrun_q;
`else
  logic unusedOverrunClr;
  assign unusedOverrunClr = overrun_clr;
  assign overrun = 1'b0;
`endif

endmodule
